// File: rtl/mod_exp_engine.sv
// Modular exponentiation core: result = base^exp mod modulus.
// Left-to-right square-and-multiply; each square or multiply step runs on a
// bit-serial interleaved modular multiplier taking exactly W cycles, so the
// latency depends only on W and the popcount of exp.
module mod_exp_engine #(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned AW = W + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t          state;
  logic [W-1:0]    base_q;
  logic [W-1:0]    exp_q;
  logic [W-1:0]    mod_q;
  logic [W-1:0]    acc_res;
  logic [W-1:0]    prod;
  logic [IW-1:0]   bit_idx;
  logic [IW-1:0]   cyc_cnt;

  logic [W-1:0]    mul_b_c;
  logic            a_bit_c;
  logic [AW-1:0]   mod_ext_c;
  logic [AW-1:0]   t0_c;
  logic [AW-1:0]   t1_c;
  logic [AW-1:0]   t2_c;
  logic [W-1:0]    step_c;

  // One multiplier iteration: p' = (2p + a[j]*b) mod n, with a = acc_res and
  // b = acc_res (square) or base (multiply). Since p, b < n, t < 3n, so two
  // conditional subtractions always suffice and W+2 bits never overflow.
  always_comb begin
    mul_b_c   = (state == MUL) ? base_q : acc_res;
    a_bit_c   = acc_res[cyc_cnt];
    mod_ext_c = {2'b00, mod_q};
    t0_c      = {1'b0, prod, 1'b0} + (a_bit_c ? {2'b00, mul_b_c} : AW'(0));
    t1_c      = (t0_c >= mod_ext_c) ? (t0_c - mod_ext_c) : t0_c;
    t2_c      = (t1_c >= mod_ext_c) ? (t1_c - mod_ext_c) : t1_c;
    step_c    = W'(t2_c);
  end

  // Control FSM, operand latches, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_q  <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      acc_res <= '0;
      prod    <= '0;
      bit_idx <= '0;
      cyc_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exp;
            mod_q  <= modulus;
            busy   <= 1'b1;
            err    <= 1'b0;
            state  <= LOAD;
          end
        end

        LOAD: begin
          bit_idx <= IW'(W - 1);
          cyc_cnt <= IW'(W - 1);
          prod    <= '0;
          if ((mod_q < W'(2)) || (base_q >= mod_q)) begin
            err     <= 1'b1;
            acc_res <= '0;
            state   <= FIN;
          end else begin
            acc_res <= W'(1);
            state   <= SQR;
          end
        end

        SQR: begin
          if (cyc_cnt != '0) begin
            prod    <= step_c;
            cyc_cnt <= cyc_cnt - IW'(1);
          end else begin
            acc_res <= step_c;
            prod    <= '0;
            cyc_cnt <= IW'(W - 1);
            if (exp_q[bit_idx]) begin
              state <= MUL;
            end else if (bit_idx == '0) begin
              state <= FIN;
            end else begin
              bit_idx <= bit_idx - IW'(1);
            end
          end
        end

        MUL: begin
          if (cyc_cnt != '0) begin
            prod    <= step_c;
            cyc_cnt <= cyc_cnt - IW'(1);
          end else begin
            acc_res <= step_c;
            prod    <= '0;
            cyc_cnt <= IW'(W - 1);
            if (bit_idx == '0) begin
              state <= FIN;
            end else begin
              bit_idx <= bit_idx - IW'(1);
              state   <= SQR;
            end
          end
        end

        FIN: begin
          result <= err ? '0 : acc_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Bench for mod_exp_engine: directed and random vectors on W=8, W=16 and
// W=128 instances, checked against a right-to-left exponentiation model.
module tb_mod_exp_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start8 = 1'b0, busy8, done8, err8;
  logic [7:0]   base8 = '0, exp8 = '0, mod8 = '0, res8;
  logic         start16 = 1'b0, busy16, done16, err16;
  logic [15:0]  base16 = '0, exp16 = '0, mod16 = '0, res16;
  logic         start128 = 1'b0, busy128, done128, err128;
  logic [127:0] base128 = '0, exp128 = '0, mod128 = '0, res128;

  mod_exp_engine #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .base(base8), .exp(exp8),
    .modulus(mod8), .busy(busy8), .done(done8), .err(err8), .result(res8)
  );
  mod_exp_engine #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .base(base16), .exp(exp16),
    .modulus(mod16), .busy(busy16), .done(done16), .err(err16), .result(res16)
  );
  mod_exp_engine #(.W(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .base(base128), .exp(exp128),
    .modulus(mod128), .busy(busy128), .done(done128), .err(err128), .result(res128)
  );

  int total = 0;
  int bad = 0;
  int sel = 8;
  logic         cur_busy, cur_done, cur_err;
  logic [127:0] cur_res;

  always_comb begin
    case (sel)
      8:       begin cur_busy = busy8;   cur_done = done8;   cur_err = err8;   cur_res = 128'(res8);  end
      16:      begin cur_busy = busy16;  cur_done = done16;  cur_err = err16;  cur_res = 128'(res16); end
      default: begin cur_busy = busy128; cur_done = done128; cur_err = err128; cur_res = res128;       end
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: right-to-left binary exponentiation with wide arithmetic.
  function automatic logic [127:0] model(input logic [127:0] b, input logic [127:0] e,
                                         input logic [127:0] n, input int w);
    logic [255:0] r, x, nn;
    if (n < 2 || b >= n) return '0;
    nn = 256'(n);
    r  = 256'(1);
    x  = 256'(b);
    for (int i = 0; i < w; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return r[127:0];
  endfunction

  task automatic drive(input int w, input logic s, input logic [127:0] b,
                       input logic [127:0] e, input logic [127:0] n);
    case (w)
      8:       begin start8 = s;   base8 = b[7:0];   exp8 = e[7:0];   mod8 = n[7:0];   end
      16:      begin start16 = s;  base16 = b[15:0]; exp16 = e[15:0]; mod16 = n[15:0]; end
      default: begin start128 = s; base128 = b;      exp128 = e;      mod128 = n;      end
    endcase
  endtask

  // One full operation; poke re-pulses start while busy (must be ignored).
  task automatic op(input int w, input logic [127:0] b, input logic [127:0] e,
                    input logic [127:0] n, input string tag, input bit poke);
    logic [127:0] exp_res;
    logic         exp_err;
    int           exp_lat, lat, limit;
    bit           busy_ok;
    exp_err = (n < 2) || (b >= n);
    exp_res = model(b, e, n, w);
    exp_lat = exp_err ? 2 : 2 + w * w + $countones(e) * w;
    limit   = 2 * w * w + 2 * w + 10;
    sel = w;
    @(negedge clk);
    drive(w, 1'b1, b, e, n);
    @(posedge clk); #1;
    drive(w, 1'b0, b, e, n);
    chk({tag, "/busy_accept"}, 128'(cur_busy), 128'(1));
    lat = 0;
    busy_ok = 1'b1;
    while (!cur_done && lat < limit) begin
      if (poke && lat == 5) drive(w, 1'b1, 128'(1), 128'(5), n);
      else drive(w, 1'b0, b, e, n);
      @(posedge clk); #1;
      lat++;
      if (!cur_done && !cur_busy) busy_ok = 1'b0;
    end
    drive(w, 1'b0, b, e, n);
    chk({tag, "/done"}, 128'(cur_done), 128'(1));
    chk({tag, "/latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "/result"}, cur_res, exp_res);
    chk({tag, "/err"}, 128'(cur_err), 128'(exp_err));
    chk({tag, "/busy_low"}, 128'(cur_busy), 128'(0));
    chk({tag, "/busy_held"}, 128'(busy_ok), 128'(1));
  endtask

  initial begin
    logic [127:0] rb, re, rn;
    int dones;

    // reset state
    #23 rst_n = 1'b1;
    #1;
    chk("rst/busy", 128'(busy8), 128'(0));
    chk("rst/done", 128'(done8), 128'(0));
    chk("rst/err", 128'(err8), 128'(0));
    chk("rst/result", 128'(res8), 128'(0));
    chk("rst/busy128", 128'(busy128), 128'(0));

    // directed vectors
    op(8, 4, 3, 33, "t1", 1'b0);
    op(8, 31, 7, 33, "t2", 1'b0);
    op(8, 5, 0, 33, "t3_exp0", 1'b0);
    op(8, 0, 5, 33, "t3_base0", 1'b0);
    op(8, 40, 3, 33, "t4_base_ge_n", 1'b0);
    @(posedge clk); #1;
    chk("t4/done_pulse", 128'(done8), 128'(0));
    chk("t4/err_held", 128'(err8), 128'(1));
    op(8, 0, 3, 1, "t4_mod1", 1'b0);
    op(8, 1, 200, 33, "base1", 1'b0);
    op(8, 254, 255, 255, "max8", 1'b0);
    op(16, 4, 3, 33, "t5a", 1'b1);
    op(16, 2, 10, 1000, "t5b", 1'b0);

    // asynchronous reset mid-SQR
    sel = 8;
    @(negedge clk);
    drive(8, 1'b1, 4, 3, 33);
    @(posedge clk); #1;
    drive(8, 1'b0, 4, 3, 33);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6/busy", 128'(busy8), 128'(0));
    chk("t6/done", 128'(done8), 128'(0));
    chk("t6/err", 128'(err8), 128'(0));
    chk("t6/result", 128'(res8), 128'(0));
    #3 rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) dones++;
    end
    chk("t6/no_done_after_reset", 128'(dones), 128'(0));

    // random W=8 and W=16
    for (int k = 0; k < 16; k++) begin
      rn = 128'($urandom_range(2, 255));
      rb = 128'($urandom_range(0, 32'(rn) - 1));
      re = 128'($urandom_range(0, 255));
      op(8, rb, re, rn, $sformatf("rnd8_%0d", k), 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      rn = 128'($urandom_range(2, 65535));
      rb = 128'($urandom_range(0, 32'(rn) - 1));
      re = 128'($urandom_range(0, 65535));
      op(16, rb, re, rn, $sformatf("rnd16_%0d", k), 1'b0);
    end

    // random W=128
    for (int k = 0; k < 2; k++) begin
      rn = {$urandom, $urandom, $urandom, $urandom} | 128'(2);
      rb = {$urandom, $urandom, $urandom, $urandom} % rn;
      re = {$urandom, $urandom, $urandom, $urandom};
      op(128, rb, re, rn, $sformatf("rnd128_%0d", k), 1'b0);
    end
    rn = {1'b1, 95'(0), $urandom} | 128'(3);
    rb = {$urandom, $urandom, $urandom, $urandom} % rn;
    op(128, rb, 128'(65537), rn, "rsa128_e65537", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
